cpu_bus_responder: RTL and testbench

Memory-side responder for the CPU's instruction/data request interface. Each CPU cycle presents one instruction fetch (`im_addr`) and at most one data access (`dm_*`). The block serialises both onto a single shared synchronous SRAM port and holds `bus_stall` high until both complete. It then releases `bus_stall` for exactly one cycle with `im_dataout`/`dm_dataout` valid. It sits between CPU and the SRAM macro in the top level.

---
 rtl/cpu_bus_pkg.sv | 23 ++
 rtl/bus_addr_decode.sv | 24 ++
 rtl/cpu_bus_responder.sv | 189 ++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_pkg
//  Description : Shared types and constants for the CPU bus responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

    // Transaction sequencer states: fetch first, then the optional data access
    typedef enum logic [2:0] {
        ST_IF_ISSUE = 3'd0,
        ST_IF_WAIT  = 3'd1,
        ST_DM_ISSUE = 3'd2,
        ST_DM_WAIT  = 3'd3,
        ST_DONE     = 3'd4
    } bus_state_t;

    localparam logic [15:0] IM_REGION = 16'h0000;
    localparam logic [15:0] DM_REGION = 16'h0001;
    localparam logic [3:0]  WEB_NONE  = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/bus_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : bus_addr_decode
//  Description : Maps a 32-bit CPU address onto the shared SRAM word address
//                and flags whether it falls inside a legal region.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_addr_decode
    import cpu_bus_pkg::*;
(
    input  logic [31:0] addr,
    output logic [14:0] sram_a,
    output logic        in_region
);

    // Region bit selects the SRAM half; bits [15:14] must be clear to be legal
    always_comb begin
        sram_a    = {addr[16], addr[13:0]};
        in_region = ((addr[31:16] == IM_REGION) || (addr[31:16] == DM_REGION))
                    && (addr[15:14] == 2'b00);
    end

endmodule
`default_nettype wire

// File: rtl/cpu_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_responder
//  Description : Serialises one instruction fetch and at most one data access
//                per CPU cycle onto a single synchronous SRAM port, stalling
//                the CPU until both have completed.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] im_addr,
    input  logic        im_read_mem,
    input  logic [31:0] dm_addr,
    input  logic        dm_read_mem,
    input  logic        dm_write_mem,
    input  logic [3:0]  dm_web,
    input  logic [31:0] dm_datain,
    output logic [31:0] im_dataout,
    output logic [31:0] dm_dataout,
    output logic        bus_stall,
    output logic        bus_err,
    output logic        sram_cs,
    output logic        sram_oe,
    output logic [3:0]  sram_web,
    output logic [14:0] sram_a,
    output logic [31:0] sram_di,
    input  logic [31:0] sram_do
);

    localparam int                 c_cnt_w     = $clog2(WAIT_CYCLES + 2);
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    bus_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;

    logic [14:0] w_if_a;
    logic        w_if_in;
    logic [14:0] w_dm_a;
    logic        w_dm_in;
    logic        w_dm_req;

    // Request snapshot taken in IF_ISSUE; later input changes are ignored
    logic [14:0] r_if_a;
    logic        r_if_ok;
    logic [14:0] r_dm_a;
    logic        r_dm_ok;
    logic        r_dm_rd;
    logic        r_dm_wr;
    logic [3:0]  r_dm_web;
    logic [31:0] r_dm_di;

    bus_addr_decode u_if_dec (
        .addr      (im_addr),
        .sram_a    (w_if_a),
        .in_region (w_if_in)
    );

    bus_addr_decode u_dm_dec (
        .addr      (dm_addr),
        .sram_a    (w_dm_a),
        .in_region (w_dm_in)
    );

    assign w_dm_req  = dm_read_mem | dm_write_mem;
    assign bus_stall = (r_state != ST_DONE);

    // Sequencer: latch request, run fetch then data phase, release for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IF_ISSUE;
            r_cnt      <= '0;
            r_if_a     <= '0;
            r_if_ok    <= 1'b0;
            r_dm_a     <= '0;
            r_dm_ok    <= 1'b0;
            r_dm_rd    <= 1'b0;
            r_dm_wr    <= 1'b0;
            r_dm_web   <= WEB_NONE;
            r_dm_di    <= '0;
            im_dataout <= '0;
            dm_dataout <= '0;
            bus_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IF_ISSUE: begin
                    r_if_a   <= w_if_a;
                    r_if_ok  <= im_read_mem & w_if_in;
                    r_dm_a   <= w_dm_a;
                    r_dm_ok  <= w_dm_req & w_dm_in;
                    r_dm_rd  <= dm_read_mem;
                    r_dm_wr  <= dm_write_mem;
                    r_dm_web <= dm_web;
                    r_dm_di  <= dm_datain;
                    r_cnt    <= c_wait_load;
                    if ((im_read_mem && !w_if_in) || (w_dm_req && !w_dm_in))
                        bus_err <= 1'b1;
                    if (im_read_mem)
                        r_state <= ST_IF_WAIT;
                    else if (w_dm_req)
                        r_state <= ST_DM_ISSUE;
                    else
                        r_state <= ST_DONE;
                end
                ST_IF_WAIT: begin
                    if (r_cnt == '0) begin
                        // Out-of-region fetches never reach the SRAM and read as zero
                        im_dataout <= r_if_ok ? sram_do : 32'd0;
                        r_state    <= (r_dm_rd | r_dm_wr) ? ST_DM_ISSUE : ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_DM_ISSUE: begin
                    r_cnt   <= c_wait_load;
                    r_state <= ST_DM_WAIT;
                end
                ST_DM_WAIT: begin
                    if (r_cnt == '0) begin
                        // A combined read+write is treated as a write: read data untouched
                        if (r_dm_rd && !r_dm_wr)
                            dm_dataout <= r_dm_ok ? sram_do : 32'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IF_ISSUE;
                end
                default: begin
                    r_state <= ST_IF_ISSUE;
                end
            endcase
        end
    end

    // SRAM port drive; the fetch issue uses the live address so the SRAM
    // samples it on the same edge that snapshots the request
    always_comb begin
        sram_cs  = 1'b0;
        sram_oe  = 1'b0;
        sram_web = WEB_NONE;
        sram_a   = '0;
        sram_di  = '0;
        case (r_state)
            ST_IF_ISSUE: begin
                if (!rst && im_read_mem && w_if_in) begin
                    sram_cs = 1'b1;
                    sram_oe = 1'b1;
                    sram_a  = w_if_a;
                end
            end
            ST_IF_WAIT: begin
                if (r_if_ok) begin
                    sram_oe = 1'b1;
                    sram_a  = r_if_a;
                end
            end
            ST_DM_ISSUE: begin
                if (r_dm_ok) begin
                    sram_cs = 1'b1;
                    sram_a  = r_dm_a;
                    if (r_dm_wr) begin
                        sram_web = r_dm_web;
                        sram_di  = r_dm_di;
                    end else begin
                        sram_oe = 1'b1;
                    end
                end
            end
            ST_DM_WAIT: begin
                if (r_dm_ok && !r_dm_wr) begin
                    sram_oe = 1'b1;
                    sram_a  = r_dm_a;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_bus_responder
//  Description : Self-checking bench; two responders (WAIT_CYCLES 0 and 2)
//                each behind a behavioural SRAM, checked against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0] im_addr      [2];
    logic        im_read_mem  [2];
    logic [31:0] dm_addr      [2];
    logic        dm_read_mem  [2];
    logic        dm_write_mem [2];
    logic [3:0]  dm_web       [2];
    logic [31:0] dm_datain    [2];
    logic [31:0] im_dataout   [2];
    logic [31:0] dm_dataout   [2];
    logic        bus_stall    [2];
    logic        bus_err      [2];
    logic        sram_cs      [2];
    logic        sram_oe      [2];
    logic [3:0]  sram_web     [2];
    logic [14:0] sram_a       [2];
    logic [31:0] sram_di      [2];
    logic [31:0] sram_do      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            cpu_bus_responder #(.WAIT_CYCLES(g * 2)) u_dut (
                .clk          (clk),
                .rst          (rst),
                .im_addr      (im_addr[g]),
                .im_read_mem  (im_read_mem[g]),
                .dm_addr      (dm_addr[g]),
                .dm_read_mem  (dm_read_mem[g]),
                .dm_write_mem (dm_write_mem[g]),
                .dm_web       (dm_web[g]),
                .dm_datain    (dm_datain[g]),
                .im_dataout   (im_dataout[g]),
                .dm_dataout   (dm_dataout[g]),
                .bus_stall    (bus_stall[g]),
                .bus_err      (bus_err[g]),
                .sram_cs      (sram_cs[g]),
                .sram_oe      (sram_oe[g]),
                .sram_web     (sram_web[g]),
                .sram_a       (sram_a[g]),
                .sram_di      (sram_di[g]),
                .sram_do      (sram_do[g])
            );
        end
    endgenerate

    function automatic int wv(input int d);
        return d * 2;
    endfunction

    function automatic logic [31:0] init_word(input int d, input int i);
        if (d == 0 && i == 4) return 32'h0000_0093;
        if (i == 16384 + 12)  return 32'h1122_3344;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_9E37) ^ 32'(d);
    endfunction

    function automatic bit in_reg(input logic [31:0] a);
        logic [15:0] hi;
        logic [1:0]  mid;
        hi  = a[31:16];
        mid = a[15:14];
        return (hi <= 16'd1) && (mid == 2'd0);
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'(a[16]) * 16384 + int'(a[13:0]);
    endfunction

    // Behavioural SRAM: writes commit on the sampling edge, read data is
    // presented only for the single cycle WAIT_CYCLES+1 edges after issue
    logic [31:0] sram_mem [2][32768];
    logic [31:0] rd_hold  [2];
    int          rd_age   [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32768; i++) sram_mem[d][i] = init_word(d, i);
            rd_age[d]  = -1;
            rd_hold[d] = '0;
            sram_do[d] = '0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (sram_cs[d] && (sram_web[d] != 4'hF)) begin
                    for (int b = 0; b < 4; b++)
                        if (!sram_web[d][b])
                            sram_mem[d][sram_a[d]][8*b +: 8] = sram_di[d][8*b +: 8];
                    rd_age[d] = -1;
                end else if (sram_cs[d] && sram_oe[d]) begin
                    rd_hold[d] = sram_mem[d][sram_a[d]];
                    rd_age[d]  = 0;
                end else if (rd_age[d] >= 0) begin
                    rd_age[d] = rd_age[d] + 1;
                end
                if (rd_age[d] == wv(d)) sram_do[d] <= rd_hold[d];
                else                    sram_do[d] <= $urandom;
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [2][32768];
    logic [31:0] exp_im  [2];
    logic [31:0] exp_dm  [2];
    logic        exp_err [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle(input int d);
        im_read_mem[d]  = 1'b0;
        dm_read_mem[d]  = 1'b0;
        dm_write_mem[d] = 1'b0;
        dm_web[d]       = 4'hF;
    endtask

    task automatic wait_done(input int d);
        int k;
        k = 0;
        while (bus_stall[d] && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("release%0d", d), 32'(bus_stall[d]), 32'd0);
    endtask

    task automatic drive(input int d, input logic [31:0] ia, input logic ir,
                         input logic [31:0] da, input logic dr, input logic dw,
                         input logic [3:0] web, input logic [31:0] di);
        if (bus_stall[d]) wait_done(d);
        im_addr[d]      = ia;
        im_read_mem[d]  = ir;
        dm_addr[d]      = da;
        dm_read_mem[d]  = dr;
        dm_write_mem[d] = dw;
        dm_web[d]       = web;
        dm_datain[d]    = di;
    endtask

    task automatic txn(input int d, input logic [31:0] ia, input logic ir,
                       input logic [31:0] da, input logic dr, input logic dw,
                       input logic [3:0] web, input logic [31:0] di,
                       input string tag, output int n);
        int  cs_n;
        int  exp_n;
        int  exp_cs;
        bit  f_ok;
        bit  d_ok;
        bit  dreq;
        drive(d, ia, ir, da, dr, dw, web, di);
        n    = 0;
        cs_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (sram_cs[d]) cs_n++;
        end while (bus_stall[d] && n < 64);

        f_ok = ir && in_reg(ia);
        dreq = dr || dw;
        d_ok = dreq && in_reg(da);
        if ((ir && !in_reg(ia)) || (dreq && !in_reg(da))) exp_err[d] = 1'b1;
        if (ir) exp_im[d] = f_ok ? ref_mem[d][idx(ia)] : 32'd0;
        if (dw) begin
            if (d_ok)
                for (int b = 0; b < 4; b++)
                    if (!web[b]) ref_mem[d][idx(da)][8*b +: 8] = di[8*b +: 8];
        end else if (dr) begin
            exp_dm[d] = d_ok ? ref_mem[d][idx(da)] : 32'd0;
        end
        exp_n  = (ir ? wv(d) + 3 : 2) + (dreq ? wv(d) + 2 : 0);
        exp_cs = int'(f_ok) + int'(d_ok);

        chk({tag, " cycles"}, 32'(n), 32'(exp_n));
        chk({tag, " cs_pulses"}, 32'(cs_n), 32'(exp_cs));
        chk({tag, " im_dataout"}, im_dataout[d], exp_im[d]);
        chk({tag, " dm_dataout"}, dm_dataout[d], exp_dm[d]);
        chk({tag, " bus_err"}, 32'(bus_err[d]), 32'(exp_err[d]));
        set_idle(d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle(0);
        set_idle(1);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d im_dataout", d), im_dataout[d], 32'd0);
            chk($sformatf("rst%0d dm_dataout", d), dm_dataout[d], 32'd0);
            chk($sformatf("rst%0d bus_stall", d), 32'(bus_stall[d]), 32'd1);
            chk($sformatf("rst%0d bus_err", d), 32'(bus_err[d]), 32'd0);
            chk($sformatf("rst%0d sram_cs", d), 32'(sram_cs[d]), 32'd0);
            chk($sformatf("rst%0d sram_oe", d), 32'(sram_oe[d]), 32'd0);
            chk($sformatf("rst%0d sram_web", d), 32'(sram_web[d]), 32'hF);
            chk($sformatf("rst%0d sram_a", d), 32'(sram_a[d]), 32'd0);
            chk($sformatf("rst%0d sram_di", d), sram_di[d], 32'd0);
            exp_im[d]  = '0;
            exp_dm[d]  = '0;
            exp_err[d] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          s;
        s = $urandom_range(0, 15);
        a = {15'd0, 1'($urandom_range(0, 1)), 2'b00, 14'($urandom_range(0, 15))};
        if (s == 0)      a[31:16] = 16'h0002 + 16'($urandom_range(0, 100));
        else if (s == 1) a[15:14] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        int          n;
        logic [31:0] held;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32768; i++) ref_mem[d][i] = init_word(d, i);
            im_addr[d]   = '0;
            dm_addr[d]   = '0;
            dm_datain[d] = '0;
            set_idle(d);
        end
        @(negedge clk);
        do_reset();

        // Fetch only, single-cycle SRAM
        txn(0, 32'h0000_0004, 1, 32'h0, 0, 0, 4'hF, 32'h0, "fetch", n);
        chk("fetch literal", im_dataout[0], 32'h0000_0093);
        chk("fetch len", 32'(n), 32'd3);

        // Store then load
        txn(0, 32'h0000_0000, 1, 32'h0001_0008, 0, 1, 4'b0000, 32'hDEAD_BEEF, "store", n);
        chk("store len", 32'(n), 32'd5);
        txn(0, 32'h0000_0000, 1, 32'h0001_0008, 1, 0, 4'hF, 32'h0, "load", n);
        chk("load literal", dm_dataout[0], 32'hDEAD_BEEF);
        chk("load len", 32'(n), 32'd5);

        // Byte-lane write
        txn(0, 32'h0000_0004, 1, 32'h0001_000C, 0, 1, 4'b1110, 32'h0000_00AA, "bytewr", n);
        txn(0, 32'h0000_0004, 1, 32'h0001_000C, 1, 0, 4'hF, 32'h0, "byterd", n);
        chk("byte literal", dm_dataout[0], 32'h1122_33AA);

        // Latency sweep on the WAIT_CYCLES=2 instance
        txn(1, 32'h0000_0008, 1, 32'h0, 0, 0, 4'hF, 32'h0, "w2fetch", n);
        chk("w2 fetch len", 32'(n), 32'd5);
        txn(1, 32'h0000_0008, 1, 32'h0001_0004, 1, 0, 4'hF, 32'h0, "w2load", n);
        chk("w2 load len", 32'(n), 32'd9);

        // Skipped fetch with a load: instruction output holds
        held = im_dataout[0];
        txn(0, 32'h0000_0003, 0, 32'h0001_0008, 1, 0, 4'hF, 32'h0, "nofetch", n);
        chk("nofetch im held", im_dataout[0], held);

        // Read and write together: write wins, read data unchanged
        txn(0, 32'h0000_0004, 1, 32'h0001_0010, 1, 1, 4'b0000, 32'h0BAD_C0DE, "rdwr", n);
        chk("rdwr dm held", dm_dataout[0], 32'hDEAD_BEEF);
        txn(0, 32'h0000_0004, 1, 32'h0001_0010, 1, 0, 4'hF, 32'h0, "rdwr_chk", n);
        chk("rdwr write landed", dm_dataout[0], 32'h0BAD_C0DE);

        // Out-of-region read, then stickiness
        txn(0, 32'h0000_0004, 1, 32'h0002_0000, 1, 0, 4'hF, 32'h0, "oor", n);
        chk("oor dm zero", dm_dataout[0], 32'd0);
        chk("oor err", 32'(bus_err[0]), 32'd1);
        txn(0, 32'h0000_0004, 1, 32'h0, 0, 0, 4'hF, 32'h0, "sticky", n);
        chk("err sticky", 32'(bus_err[0]), 32'd1);

        // Randomised traffic on both instances
        for (int t = 0; t < 60; t++) begin
            int d;
            d = $urandom_range(0, 1);
            txn(d, rand_addr(), 1'($urandom_range(0, 7) != 0), rand_addr(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom), $urandom, $sformatf("rnd%0d", t), n);
        end

        // Reset while a write is still pending behind the fetch
        drive(1, 32'h0000_0000, 1, 32'h0001_0020, 0, 1, 4'b0000, 32'hCAFE_F00D);
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset stall", 32'(bus_stall[1]), 32'd1);
        do_reset();
        txn(1, 32'h0000_0000, 1, 32'h0001_0020, 1, 0, 4'hF, 32'h0, "nowrite", n);

        // Reset in the data wait phase of a load
        txn(0, 32'h0000_0004, 1, 32'h0001_0014, 1, 0, 4'hF, 32'h0, "preload", n);
        drive(0, 32'h0000_0004, 1, 32'h0001_0010, 1, 0, 4'hF, 32'h0);
        repeat (4) @(negedge clk);
        chk("in dm wait", 32'(bus_stall[0]), 32'd1);
        do_reset();
        txn(0, 32'h0000_0004, 1, 32'h0, 0, 0, 4'hF, 32'h0, "fresh", n);
        chk("fresh len", 32'(n), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
